// File: rtl/demux_1to4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one shared input stream
// and four registered output channels, each with its own valid/ready.
interface demux_1to4_stream_if #(
    parameter int width  = 4,
    parameter int swidth = 2
);

    logic              in_valid;
    logic              in_ready;
    logic [width-1:0]  in_data;
    logic [swidth-1:0] in_sel;

    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [width-1:0]  o0;
    logic [width-1:0]  o1;
    logic [width-1:0]  o2;
    logic [width-1:0]  o3;

    // Producer and consumers as seen from outside the demux
    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  o0,
        input  o1,
        input  o2,
        input  o3
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output o0,
        output o1,
        output o2,
        output o3
    );

endinterface

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demux, one output register per channel.
// Optional per-channel delivered-word counters with DEMUX_CNT_EN.
module demux_1to4_stream #(
    parameter int width  = 4,
    parameter int swidth = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_1to4_stream_if.slave  bus
`ifdef DEMUX_CNT_EN
    ,
    input  logic                cnt_clr,
    output logic [7:0]          cnt0,
    output logic [7:0]          cnt1,
    output logic [7:0]          cnt2,
    output logic [7:0]          cnt3
`endif
);

    logic [3:0]       vld_q;
    logic [width-1:0] data_q [4];
    logic [3:0]       load;
    logic [3:0]       out_fire;
    logic             in_rdy;
    logic             in_fire;

    // Only the addressed channel can stall the input
    assign in_rdy  = ~vld_q[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign in_fire = bus.in_valid & in_rdy;

    assign out_fire = vld_q & bus.out_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < 4; k++) begin
            load[k] = in_fire && (bus.in_sel == swidth'(k));
        end
    end

    // Load wins over drain so a draining channel refills in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= bus.in_data;
                    vld_q[k]  <= 1'b1;
                end else if (out_fire[k]) begin
                    vld_q[k]  <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_q;
    assign bus.o0        = data_q[0];
    assign bus.o1        = data_q[1];
    assign bus.o2        = data_q[2];
    assign bus.o3        = data_q[3];

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (cnt_clr) begin
                    cnt_q[k] <= '0;
                end else if (out_fire[k]) begin
                    cnt_q[k] <= cnt_q[k] + 8'd1;
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed bench for demux_1to4_stream: vector table plus reset,
// mid-cycle reset and counter sequences.
module tb_demux_1to4_stream;

    logic clk;
    logic rst_n;

    demux_1to4_stream_if #(.width(4), .swidth(2)) bus ();

`ifdef DEMUX_CNT_EN
    logic       cnt_clr;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

    demux_1to4_stream #(.width(4), .swidth(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.master)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .cnt0   (cnt0),
        .cnt1   (cnt1),
        .cnt2   (cnt2),
        .cnt3   (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [3:0]  data;
        logic [3:0]  ordy;
        logic        x_rdy;
        logic [3:0]  x_vld;
        logic [15:0] x_o;
    } vec_t;

    vec_t vecs [16];
    int   total;
    int   bad;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel,
                         input logic [3:0] data, input logic [3:0] ordy);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = data;
        bus.out_ready = ordy;
    endtask

    function automatic logic [15:0] outs();
        return {bus.o3, bus.o2, bus.o1, bus.o0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // v sel data ordy | rdy vld {o3,o2,o1,o0}
        vecs[0]  = '{1, 0, 4'hA, 4'hF, 1, 4'b0001, 16'h000A};
        vecs[1]  = '{1, 1, 4'hB, 4'hF, 1, 4'b0010, 16'h00BA};
        vecs[2]  = '{1, 2, 4'hC, 4'hF, 1, 4'b0100, 16'h0CBA};
        vecs[3]  = '{1, 3, 4'hD, 4'hF, 1, 4'b1000, 16'hDCBA};
        vecs[4]  = '{0, 0, 4'h0, 4'hF, 1, 4'b0000, 16'hDCBA};
        vecs[5]  = '{1, 2, 4'h5, 4'hB, 1, 4'b0100, 16'hD5BA};
        vecs[6]  = '{1, 2, 4'h6, 4'hB, 0, 4'b0100, 16'hD5BA};
        vecs[7]  = '{1, 1, 4'h7, 4'hB, 1, 4'b0110, 16'hD57A};
        vecs[8]  = '{0, 1, 4'h0, 4'hB, 1, 4'b0100, 16'hD57A};
        vecs[9]  = '{1, 2, 4'h6, 4'hF, 1, 4'b0100, 16'hD67A};
        vecs[10] = '{0, 0, 4'h0, 4'hF, 1, 4'b0000, 16'hD67A};
        vecs[11] = '{1, 3, 4'h1, 4'h0, 1, 4'b1000, 16'h167A};
        vecs[12] = '{1, 3, 4'h2, 4'h0, 0, 4'b1000, 16'h167A};
        vecs[13] = '{1, 3, 4'h2, 4'h8, 1, 4'b1000, 16'h267A};
        vecs[14] = '{1, 0, 4'h9, 4'h0, 1, 4'b1001, 16'h2679};
        vecs[15] = '{0, 0, 4'h0, 4'hF, 1, 4'b0000, 16'h2679};

        rst_n = 1'b0;
        drive(0, 0, 0, 4'h0);
`ifdef DEMUX_CNT_EN
        cnt_clr = 1'b0;
`endif
        step();
        step();
        chk("rst_vld", 32'(bus.out_valid), 32'h0);
        chk("rst_o", 32'(outs()), 32'h0);
        chk("rst_rdy", 32'(bus.in_ready), 32'h1);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(bus.in_ready),
                32'(vecs[i].x_rdy));
            step();
            chk($sformatf("v%0d_vld", i), 32'(bus.out_valid),
                32'(vecs[i].x_vld));
            chk($sformatf("v%0d_o", i), 32'(outs()), 32'(vecs[i].x_o));
        end

        // Stall channel 1, then reset asynchronously mid-cycle
        drive(1, 1, 4'h3, 4'h0);
        step();
        chk("pre_rst_rdy", 32'(bus.in_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_o", 32'(outs()), 32'h0);
        chk("mid_rst_rdy", 32'(bus.in_ready), 32'h1);
        rst_n = 1'b1;
        drive(1, 1, 4'hE, 4'hF);
        step();
        chk("post_rst_vld", 32'(bus.out_valid), 32'h2);
        chk("post_rst_o1", 32'(bus.o1), 32'hE);

`ifdef DEMUX_CNT_EN
        for (int i = 0; i < 257; i++) begin
            drive(1, 0, 4'(i), 4'hF);
            step();
        end
        drive(0, 0, 0, 4'hF);
        step();
        chk("cnt0_wrap", 32'(cnt0), 32'd1);
        chk("cnt1_one", 32'(cnt1), 32'd1);
        drive(1, 1, 4'h4, 4'h0);
        step();
        cnt_clr = 1'b1;
        drive(0, 0, 0, 4'hF);
        step();
        cnt_clr = 1'b0;
        chk("cnt1_clr", 32'(cnt1), 32'd0);
        chk("cnt0_clr", 32'(cnt0), 32'd0);
        chk("clr_vld", 32'(bus.out_valid), 32'h0);
        drive(1, 2, 4'h8, 4'hF);
        step();
        drive(0, 0, 0, 4'hF);
        step();
        chk("cnt2_inc", 32'(cnt2), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
